// File: rtl/serial_comparator_lsb.sv
// Bit-serial magnitude comparator: walks both operands LSB-first, one bit per clock,
// and reports {0, gt, lt, eq} under a start/done handshake.
module serial_comparator_lsb #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic             busy,
    output logic             done,
    output logic [3:0]       out,
    output logic             cout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;
    logic               eq_q, eq_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2:0]         res_q, res_d;

    // Running decision including the bit currently at position 0; a differing
    // bit always wins because later bits are more significant.
    logic bit_diff;
    logic gt_step, lt_step, eq_step;

    always_comb begin
        bit_diff = a_q[0] ^ b_q[0];
        gt_step  = bit_diff ?  a_q[0] : gt_q;
        lt_step  = bit_diff ? ~a_q[0] : lt_q;
        eq_step  = bit_diff ?  1'b0   : eq_q;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        count_d = count_q;
        res_d   = res_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = num1;
                    b_d     = num2;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    count_d = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                gt_d    = gt_step;
                lt_d    = lt_step;
                eq_d    = eq_step;
                count_d = count_q + 1'b1;
                if (count_q == LAST_BIT) begin
                    res_d   = {gt_step, lt_step, eq_step};
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            count_q <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            count_q <= count_d;
            res_q   <= res_d;
        end
    end

    // DONE lasts exactly one cycle, so decoding it gives the single-cycle pulse.
    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);
    assign out  = {1'b0, res_q};
    assign cout = 1'b0;

endmodule
